// File: rtl/text_overlay_ctrl_if.sv
// ============================================================================
// Module      : text_overlay_ctrl_if
// Description : Write, clear, pixel and glyph-ROM signals of the text overlay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface text_overlay_ctrl_if #(
    parameter int COLS = 16,
    parameter int ROWS = 4
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic          wr_valid;
    logic          wr_ready;
    logic [CW-1:0] wr_col;
    logic [RW-1:0] wr_row;
    logic [7:0]    wr_char;
    logic          clr_req;
    logic          busy;
    logic          px_valid;
    logic [9:0]    px_x;
    logic [9:0]    px_y;
    logic [7:0]    ch;
    logic [2:0]    xoff;
    logic [2:0]    yoff;
    logic          rom_pixel;
    logic          text_valid;
    logic          text_on;

    modport master (
        output wr_valid, wr_col, wr_row, wr_char, clr_req,
        output px_valid, px_x, px_y, rom_pixel,
        input  wr_ready, busy, ch, xoff, yoff, text_valid, text_on
    );

    modport slave (
        input  wr_valid, wr_col, wr_row, wr_char, clr_req,
        input  px_valid, px_x, px_y, rom_pixel,
        output wr_ready, busy, ch, xoff, yoff, text_valid, text_on
    );
endinterface

`default_nettype wire

// File: rtl/text_overlay_ctrl.sv
// ============================================================================
// Module      : text_overlay_ctrl
// Description : Text buffer, clear engine and 3-stage char-ROM pixel pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_overlay_ctrl #(
    parameter int COLS       = 16,
    parameter int ROWS       = 4,
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int SCALE_LOG2 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    text_overlay_ctrl_if.slave   bus
);
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = CW + RW;
    localparam int DEPTH = COLS * ROWS;
    localparam int REG_W = COLS * 8 * (1 << SCALE_LOG2);
    localparam int REG_H = ROWS * 8 * (1 << SCALE_LOG2);
    localparam int SH    = 3 + SCALE_LOG2;

    localparam logic [7:0]    c_BLANK  = 8'h20;
    localparam logic [7:0]    c_CH_MIN = 8'd65;
    localparam logic [7:0]    c_CH_MAX = 8'd90;
    localparam logic [AW-1:0] c_LAST   = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          wr_ready_d;
    logic          wr_fire_d;

    logic [7:0]    mem_q [DEPTH];

    // ---------------- clear engine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                clr_addr_d = '0;
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == c_LAST) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // A clear request in the same cycle as a write steals the slot.
    assign wr_ready_d   = (state_q == ST_IDLE) && !bus.clr_req;
    assign wr_fire_d    = bus.wr_valid && wr_ready_d;
    assign bus.wr_ready = wr_ready_d;
    assign bus.busy     = (state_q == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_CLEAR) begin
            mem_q[clr_addr_q] <= c_BLANK;
        end else if (!rst && wr_fire_d) begin
            mem_q[{bus.wr_row, bus.wr_col}] <= bus.wr_char;
        end
    end

    // ---------------- S1: coordinate mapping ----------------
    logic [9:0]    rx_d, ry_d;
    logic          hit_d;
    logic [CW-1:0] col_d;
    logic [RW-1:0] row_d;
    logic [2:0]    xo_d, yo_d;

    assign rx_d  = bus.px_x - 10'(X0);
    assign ry_d  = bus.px_y - 10'(Y0);
    assign hit_d = bus.px_valid
                && (bus.px_x >= 10'(X0)) && ({22'd0, rx_d} < 32'(REG_W))
                && (bus.px_y >= 10'(Y0)) && ({22'd0, ry_d} < 32'(REG_H));
    assign col_d = CW'(rx_d >> SH);
    assign row_d = RW'(ry_d >> SH);
    assign xo_d  = 3'(rx_d >> SCALE_LOG2);
    assign yo_d  = 3'(ry_d >> SCALE_LOG2);

    logic          s1_valid_q, s1_hit_q;
    logic [2:0]    s1_xoff_q, s1_yoff_q;
    logic [AW-1:0] s1_addr_q;

    // ---------------- S2: buffer read, ROM drive ----------------
    logic [7:0] rd_data_d;
    logic       disp_d;

    assign rd_data_d = mem_q[s1_addr_q];
    assign disp_d    = (rd_data_d >= c_CH_MIN) && (rd_data_d <= c_CH_MAX);

    logic       s2_valid_q, s2_hit_q, s2_disp_q;
    logic [7:0] ch_q;
    logic [2:0] xoff_q, yoff_q;

    // ---------------- S3: registered pixel ----------------
    logic text_valid_q, text_on_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_xoff_q    <= 3'd0;
            s1_yoff_q    <= 3'd0;
            s1_addr_q    <= '0;
            s2_valid_q   <= 1'b0;
            s2_hit_q     <= 1'b0;
            s2_disp_q    <= 1'b0;
            ch_q         <= c_CH_MIN;
            xoff_q       <= 3'd0;
            yoff_q       <= 3'd0;
            text_valid_q <= 1'b0;
            text_on_q    <= 1'b0;
        end else begin
            s1_valid_q   <= bus.px_valid;
            s1_hit_q     <= hit_d;
            s1_xoff_q    <= xo_d;
            s1_yoff_q    <= yo_d;
            s1_addr_q    <= {row_d, col_d};
            s2_valid_q   <= s1_valid_q;
            s2_hit_q     <= s1_hit_q;
            s2_disp_q    <= disp_d;
            // Non-glyph codes are parked on 'A' so the ROM index stays legal.
            ch_q         <= disp_d ? rd_data_d : c_CH_MIN;
            xoff_q       <= s1_xoff_q;
            yoff_q       <= s1_yoff_q;
            text_valid_q <= s2_valid_q;
            text_on_q    <= s2_valid_q && s2_hit_q && s2_disp_q && bus.rom_pixel;
        end
    end

    assign bus.ch         = ch_q;
    assign bus.xoff       = xoff_q;
    assign bus.yoff       = yoff_q;
    assign bus.text_valid = text_valid_q;
    assign bus.text_on    = text_on_q;

endmodule

`default_nettype wire
